// File: rtl/axi_gmem_rd_wr_responder.sv
// AXI4 memory-side responder for a kernel gmem master port.
// Queues read bursts and returns patterned data after a fixed latency, with
// optional idle gaps between beats. Sinks write bursts and answers each with
// a B response. The read and write paths share no state.
//
// Ports:
//   ap_clk, ap_reset                      clock, synchronous active-high reset
//   arvalid/arready/araddr/arid/arlen     read address channel
//   rvalid/rready/rdata/rid/rresp/rlast   read data channel
//   awvalid/awready/awid/awlen            write address channel
//   wvalid/wready/wlast                   write data channel (data is dropped)
//   bvalid/bready/bid/bresp               write response channel
//   rd_beats, wr_beats                    R / W handshakes since reset
//   wlast_err                             sticky: wlast disagreed with awlen
//
// Read engine states:
//   state  | meaning
//   R_IDLE | no burst active, pop the queue head when one is present
//   R_WAIT | latency timer counting down to the first beat
//   R_BEAT | rvalid high, beat held until rready
//   R_GAP  | inter-beat idle, rvalid low
//
// Write sink states:
//   state  | meaning
//   W_ADDR | awready high, waiting for a burst
//   W_DATA | wready high, sinking beats
//   W_RESP | bvalid high until bready
module axi_gmem_rd_wr_responder #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int AR_DEPTH   = 4,
  parameter int LATENCY    = 8,
  parameter int BEAT_GAP   = 0,
  parameter int PATTERN    = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_reset,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [7:0]            arlen,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [1:0]            rresp,
  output logic                  rlast,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [7:0]            awlen,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic [31:0]           rd_beats,
  output logic [31:0]           wr_beats,
  output logic                  wlast_err
);

  localparam int PW = $clog2(AR_DEPTH);
  localparam int BYTES = DATA_WIDTH / 8;
  // WAIT is entered one cycle after the AR handshake, and leaving WAIT takes
  // one more edge after terminal count, hence LATENCY-2.
  localparam logic [15:0] WAIT_LOAD = 16'(LATENCY - 2);
  localparam logic [15:0] GAP_LOAD  = (BEAT_GAP > 0) ? 16'(BEAT_GAP - 1) : 16'd0;

  // ---------------- AR queue ----------------
  logic [ADDR_WIDTH-1:0] q_addr [AR_DEPTH];
  logic [ID_WIDTH-1:0]   q_id   [AR_DEPTH];
  logic [7:0]            q_len  [AR_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           q_count, q_count_next;
  logic                  push, pop, q_empty;

  assign push    = arvalid && arready;
  assign q_empty = (q_count == '0);

  always_comb begin
    q_count_next = q_count;
    case ({push, pop})
      2'b10:   q_count_next = q_count + (PW+1)'(1);
      2'b01:   q_count_next = q_count - (PW+1)'(1);
      default: q_count_next = q_count;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (push) begin
      q_addr[wr_ptr] <= araddr;
      q_id[wr_ptr]   <= arid;
      q_len[wr_ptr]  <= arlen;
    end
  end

  // arready is registered from the next occupancy, so a pop while full only
  // reopens the queue on the following cycle.
  always_ff @(posedge ap_clk) begin
    if (ap_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
      arready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      q_count <= q_count_next;
      arready <= (q_count_next != (PW+1)'(AR_DEPTH));
    end
  end

  // ---------------- Read engine ----------------
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT, R_GAP} rd_state_t;
  rd_state_t rd_state, rd_next;

  logic [15:0]           rd_cnt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ID_WIDTH-1:0]   cur_id;
  logic [7:0]            cur_len, rd_beat;
  logic [DATA_WIDTH-1:0] pat_cnt;
  logic                  r_hs, last_beat;

  assign r_hs      = rvalid && rready;
  assign last_beat = (rd_beat == cur_len);

  always_comb begin
    rd_next = rd_state;
    pop     = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          rd_next = R_WAIT;
        end
      end
      R_WAIT: if (rd_cnt == '0) rd_next = R_BEAT;
      R_BEAT: begin
        rvalid = 1'b1;
        rlast  = last_beat;
        if (rready) begin
          if (last_beat) begin
            if (!q_empty) begin
              pop     = 1'b1;
              rd_next = R_WAIT;
            end else begin
              rd_next = R_IDLE;
            end
          end else if (BEAT_GAP > 0) begin
            rd_next = R_GAP;
          end
        end
      end
      R_GAP:   if (rd_cnt == '0) rd_next = R_BEAT;
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_reset) begin
      rd_state <= R_IDLE;
      rd_cnt   <= '0;
      cur_addr <= '0;
      cur_id   <= '0;
      cur_len  <= '0;
      rd_beat  <= '0;
      pat_cnt  <= '0;
      rd_beats <= '0;
    end else begin
      rd_state <= rd_next;
      if (r_hs) begin
        rd_beats <= rd_beats + 32'd1;
        pat_cnt  <= pat_cnt + DATA_WIDTH'(1);
        if (!last_beat) begin
          rd_beat  <= rd_beat + 8'd1;
          cur_addr <= cur_addr + ADDR_WIDTH'(BYTES);
          rd_cnt   <= GAP_LOAD;
        end
      end
      if (pop) begin
        cur_addr <= q_addr[rd_ptr];
        cur_id   <= q_id[rd_ptr];
        cur_len  <= q_len[rd_ptr];
        rd_beat  <= '0;
        rd_cnt   <= WAIT_LOAD;
      end else if ((rd_state == R_WAIT || rd_state == R_GAP) && rd_cnt != '0) begin
        rd_cnt <= rd_cnt - 16'd1;
      end
    end
  end

  assign rdata = (PATTERN != 0) ? pat_cnt : DATA_WIDTH'(cur_addr);
  assign rid   = cur_id;
  assign rresp = 2'b00;

  // ---------------- Write sink ----------------
  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} wr_state_t;
  wr_state_t wr_state, wr_next;

  logic [7:0] aw_len, wr_beat;
  logic       at_last;

  assign at_last = (wr_beat == aw_len);

  always_comb begin
    wr_next = wr_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (wr_state)
      W_ADDR: begin
        awready = 1'b1;
        if (awvalid) wr_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && (wlast || at_last)) wr_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) wr_next = W_ADDR;
      end
      default: wr_next = W_ADDR;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_reset) begin
      wr_state  <= W_ADDR;
      aw_len    <= '0;
      wr_beat   <= '0;
      bid       <= '0;
      wr_beats  <= '0;
      wlast_err <= 1'b0;
    end else begin
      wr_state <= wr_next;
      if (awvalid && awready) begin
        bid     <= awid;
        aw_len  <= awlen;
        wr_beat <= '0;
      end
      if (wvalid && wready) begin
        wr_beats <= wr_beats + 32'd1;
        wr_beat  <= wr_beat + 8'd1;
        if (wlast != at_last) wlast_err <= 1'b1;
      end
    end
  end

  assign bresp = 2'b00;

endmodule

// File: tb/tb_axi_gmem_rd_wr_responder.sv
// Directed bench for axi_gmem_rd_wr_responder.
// dut_a: address pattern, no beat gap. dut_b: counter pattern, BEAT_GAP=2.
// Inputs are driven and outputs sampled on the falling edge.
module tb_axi_gmem_rd_wr_responder;

  logic ap_clk = 1'b0;
  logic ap_reset;
  always #5 ap_clk = ~ap_clk;

  // dut_a signals
  logic        arvalid_a, arready_a, rvalid_a, rready_a, rlast_a;
  logic [63:0] araddr_a;
  logic        arid_a, rid_a;
  logic [7:0]  arlen_a;
  logic [31:0] rdata_a;
  logic [1:0]  rresp_a, bresp_a;
  logic        awvalid_a, awready_a, awid_a, wvalid_a, wready_a, wlast_a;
  logic [7:0]  awlen_a;
  logic        bvalid_a, bready_a, bid_a, wlast_err_a;
  logic [31:0] rd_beats_a, wr_beats_a;

  // dut_b signals
  logic        arvalid_b, arready_b, rvalid_b, rready_b, rlast_b;
  logic [63:0] araddr_b;
  logic        arid_b, rid_b;
  logic [7:0]  arlen_b;
  logic [31:0] rdata_b;
  logic [1:0]  rresp_b, bresp_b;
  logic        awvalid_b, awready_b, awid_b, wvalid_b, wready_b, wlast_b;
  logic [7:0]  awlen_b;
  logic        bvalid_b, bready_b, bid_b, wlast_err_b;
  logic [31:0] rd_beats_b, wr_beats_b;

  axi_gmem_rd_wr_responder #(
    .ADDR_WIDTH(64), .DATA_WIDTH(32), .ID_WIDTH(1), .AR_DEPTH(4),
    .LATENCY(8), .BEAT_GAP(0), .PATTERN(0)
  ) dut_a (
    .ap_clk(ap_clk), .ap_reset(ap_reset),
    .arvalid(arvalid_a), .arready(arready_a), .araddr(araddr_a), .arid(arid_a), .arlen(arlen_a),
    .rvalid(rvalid_a), .rready(rready_a), .rdata(rdata_a), .rid(rid_a), .rresp(rresp_a), .rlast(rlast_a),
    .awvalid(awvalid_a), .awready(awready_a), .awid(awid_a), .awlen(awlen_a),
    .wvalid(wvalid_a), .wready(wready_a), .wlast(wlast_a),
    .bvalid(bvalid_a), .bready(bready_a), .bid(bid_a), .bresp(bresp_a),
    .rd_beats(rd_beats_a), .wr_beats(wr_beats_a), .wlast_err(wlast_err_a)
  );

  axi_gmem_rd_wr_responder #(
    .ADDR_WIDTH(64), .DATA_WIDTH(32), .ID_WIDTH(1), .AR_DEPTH(4),
    .LATENCY(8), .BEAT_GAP(2), .PATTERN(1)
  ) dut_b (
    .ap_clk(ap_clk), .ap_reset(ap_reset),
    .arvalid(arvalid_b), .arready(arready_b), .araddr(araddr_b), .arid(arid_b), .arlen(arlen_b),
    .rvalid(rvalid_b), .rready(rready_b), .rdata(rdata_b), .rid(rid_b), .rresp(rresp_b), .rlast(rlast_b),
    .awvalid(awvalid_b), .awready(awready_b), .awid(awid_b), .awlen(awlen_b),
    .wvalid(wvalid_b), .wready(wready_b), .wlast(wlast_b),
    .bvalid(bvalid_b), .bready(bready_b), .bid(bid_b), .bresp(bresp_b),
    .rd_beats(rd_beats_b), .wr_beats(wr_beats_b), .wlast_err(wlast_err_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_ar_a(input logic [63:0] addr, input logic id, input logic [7:0] len);
    int n;
    araddr_a  = addr;
    arid_a    = id;
    arlen_a   = len;
    arvalid_a = 1'b1;
    n = 0;
    while (!arready_a && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    chk("ar_accept_a", 64'(n < 100), 64'd1);
    @(negedge ap_clk);
    arvalid_a = 1'b0;
  endtask

  task automatic push_ar_b(input logic [63:0] addr, input logic id, input logic [7:0] len);
    int n;
    araddr_b  = addr;
    arid_b    = id;
    arlen_b   = len;
    arvalid_b = 1'b1;
    n = 0;
    while (!arready_b && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    chk("ar_accept_b", 64'(n < 100), 64'd1);
    @(negedge ap_clk);
    arvalid_b = 1'b0;
  endtask

  task automatic wait_rvalid_a(output int n);
    n = 0;
    while (!rvalid_a && n < 60) begin
      @(negedge ap_clk);
      n++;
    end
  endtask

  task automatic wait_rvalid_b(output int n);
    n = 0;
    while (!rvalid_b && n < 60) begin
      @(negedge ap_clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int idx;
    int hits;
    logic [6:0] rr_pat;

    ap_reset  = 1'b1;
    arvalid_a = 0; araddr_a = 0; arid_a = 0; arlen_a = 0; rready_a = 0;
    awvalid_a = 0; awid_a = 0; awlen_a = 0; wvalid_a = 0; wlast_a = 0; bready_a = 0;
    arvalid_b = 0; araddr_b = 0; arid_b = 0; arlen_b = 0; rready_b = 0;
    awvalid_b = 0; awid_b = 0; awlen_b = 0; wvalid_b = 0; wlast_b = 0; bready_b = 0;
    repeat (2) @(negedge ap_clk);
    ap_reset = 1'b0;

    // reset state
    chk("rst_rvalid", rvalid_a, 0);
    chk("rst_arready", arready_a, 1);
    chk("rst_awready", awready_a, 1);
    chk("rst_wready", wready_a, 0);
    chk("rst_bvalid", bvalid_a, 0);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_rd_beats", rd_beats_a, 0);
    chk("rst_wr_beats", wr_beats_a, 0);
    chk("rst_wlast_err", wlast_err_a, 0);

    // single burst, latency and address pattern
    rready_a = 1'b1;
    push_ar_a(64'h1000, 1'b1, 8'd3);
    n = 0;
    while (!rvalid_a && n < 30) begin
      @(negedge ap_clk);
      n++;
    end
    chk("latency", n, 8);
    for (int i = 0; i < 4; i++) begin
      chk("t1_rvalid", rvalid_a, 1);
      chk("t1_rdata", rdata_a, 64'h1000 + 64'(4 * i));
      chk("t1_rlast", rlast_a, 64'(i == 3));
      chk("t1_rid", rid_a, 1);
      chk("t1_rresp", rresp_a, 0);
      @(negedge ap_clk);
    end
    chk("t1_rvalid_end", rvalid_a, 0);
    chk("t1_rd_beats", rd_beats_a, 4);

    // rready backpressure
    rready_a = 1'b0;
    push_ar_a(64'h2000, 1'b0, 8'd3);
    wait_rvalid_a(n);
    rr_pat = 7'b1101001;
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      rready_a = rr_pat[k];
      chk("t2_rvalid", rvalid_a, 1);
      chk("t2_rdata", rdata_a, 64'h2000 + 64'(4 * idx));
      chk("t2_rlast", rlast_a, 64'(idx == 3));
      @(negedge ap_clk);
      if (rr_pat[k]) idx++;
    end
    rready_a = 1'b0;
    chk("t2_rvalid_end", rvalid_a, 0);
    chk("t2_rd_beats", rd_beats_a, 8);

    // queue fill: burst 0 sits in the engine, bursts 1..4 fill the queue
    for (int i = 0; i < 5; i++) push_ar_a(64'h3000 + 64'(i * 256), 1'(i), 8'd0);
    chk("t3_ar_full", arready_a, 0);
    araddr_a  = 64'h3500;
    arid_a    = 1'b1;
    arlen_a   = 8'd0;
    arvalid_a = 1'b1;
    wait_rvalid_a(n);
    chk("t3_ar_still_full", arready_a, 0);
    chk("t3_rvalid0", rvalid_a, 1);
    chk("t3_rdata0", rdata_a, 64'h3000);
    chk("t3_rid0", rid_a, 0);
    chk("t3_rlast0", rlast_a, 1);
    rready_a = 1'b1;
    @(negedge ap_clk);
    chk("t3_ar_reopen", arready_a, 1);
    @(negedge ap_clk);
    arvalid_a = 1'b0;
    for (int i = 1; i < 6; i++) begin
      wait_rvalid_a(n);
      chk("t3_rvalid", rvalid_a, 1);
      chk("t3_rdata", rdata_a, 64'h3000 + 64'(i * 256));
      chk("t3_rid", rid_a, 64'(i % 2));
      chk("t3_rlast", rlast_a, 1);
      @(negedge ap_clk);
    end
    chk("t3_rd_beats", rd_beats_a, 14);

    // counter pattern with 2-cycle beat gap
    rready_b = 1'b1;
    push_ar_b(64'h0, 1'b0, 8'd1);
    push_ar_b(64'h100, 1'b1, 8'd1);
    for (int b = 0; b < 2; b++) begin
      wait_rvalid_b(n);
      chk("t4_rvalid_b0", rvalid_b, 1);
      chk("t4_rdata_b0", rdata_b, 64'(2 * b));
      chk("t4_rid_b0", rid_b, 64'(b));
      chk("t4_rlast_b0", rlast_b, 0);
      @(negedge ap_clk);
      chk("t4_gap1", rvalid_b, 0);
      @(negedge ap_clk);
      chk("t4_gap2", rvalid_b, 0);
      @(negedge ap_clk);
      chk("t4_rvalid_b1", rvalid_b, 1);
      chk("t4_rdata_b1", rdata_b, 64'(2 * b + 1));
      chk("t4_rlast_b1", rlast_b, 1);
      @(negedge ap_clk);
    end
    chk("t4_rd_beats", rd_beats_b, 4);

    // write burst, correct wlast, delayed bready
    awvalid_a = 1'b1; awid_a = 1'b0; awlen_a = 8'd2;
    chk("t5_awready", awready_a, 1);
    @(negedge ap_clk);
    awvalid_a = 1'b0;
    chk("t5_awready_busy", awready_a, 0);
    for (int b = 0; b < 3; b++) begin
      wvalid_a = 1'b1;
      wlast_a  = (b == 2);
      chk("t5_wready", wready_a, 1);
      @(negedge ap_clk);
    end
    wvalid_a = 1'b0; wlast_a = 1'b0;
    chk("t5_wready_off", wready_a, 0);
    chk("t5_bvalid", bvalid_a, 1);
    chk("t5_bid", bid_a, 0);
    chk("t5_bresp", bresp_a, 0);
    chk("t5_wr_beats", wr_beats_a, 3);
    chk("t5_wlast_err", wlast_err_a, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      chk("t5_bvalid_hold", bvalid_a, 1);
    end
    bready_a = 1'b1;
    @(negedge ap_clk);
    bready_a = 1'b0;
    chk("t5_bvalid_done", bvalid_a, 0);
    chk("t5_awready_back", awready_a, 1);

    // write burst with early wlast
    awvalid_a = 1'b1; awid_a = 1'b1; awlen_a = 8'd2;
    @(negedge ap_clk);
    awvalid_a = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wvalid_a = 1'b1;
      wlast_a  = (b == 1);
      @(negedge ap_clk);
    end
    wvalid_a = 1'b0; wlast_a = 1'b0;
    chk("t5e_bvalid", bvalid_a, 1);
    chk("t5e_bid", bid_a, 1);
    chk("t5e_wlast_err", wlast_err_a, 1);
    chk("t5e_wr_beats", wr_beats_a, 5);
    bready_a = 1'b1;
    @(negedge ap_clk);
    bready_a = 1'b0;
    chk("t5e_bvalid_done", bvalid_a, 0);

    // reset in the middle of a read burst and a write burst
    awvalid_a = 1'b1; awid_a = 1'b1; awlen_a = 8'd3;
    @(negedge ap_clk);
    awvalid_a = 1'b0;
    wvalid_a  = 1'b1;
    @(negedge ap_clk);
    wvalid_a  = 1'b0;
    chk("t6_wready_mid", wready_a, 1);
    rready_a = 1'b1;
    push_ar_a(64'h4000, 1'b1, 8'd3);
    wait_rvalid_a(n);
    chk("t6_rdata_b0", rdata_a, 64'h4000);
    @(negedge ap_clk);
    chk("t6_rdata_b1", rdata_a, 64'h4004);
    ap_reset = 1'b1;
    @(negedge ap_clk);
    ap_reset = 1'b0;
    chk("t6_rvalid", rvalid_a, 0);
    chk("t6_bvalid", bvalid_a, 0);
    chk("t6_wready", wready_a, 0);
    chk("t6_arready", arready_a, 1);
    chk("t6_awready", awready_a, 1);
    chk("t6_rd_beats", rd_beats_a, 0);
    chk("t6_wr_beats", wr_beats_a, 0);
    chk("t6_wlast_err", wlast_err_a, 0);
    chk("t6_rdata", rdata_a, 0);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      if (rvalid_a) hits++;
      @(negedge ap_clk);
    end
    chk("t6_no_stale", hits, 0);
    push_ar_a(64'h5000, 1'b0, 8'd0);
    n = 0;
    while (!rvalid_a && n < 30) begin
      @(negedge ap_clk);
      n++;
    end
    chk("t6_latency", n, 8);
    chk("t6_rdata_new", rdata_a, 64'h5000);
    chk("t6_rlast_new", rlast_a, 1);
    @(negedge ap_clk);
    chk("t6_rd_beats_new", rd_beats_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
